addsub_arbiter: RTL and testbench
=================================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: clock cycles the adder inputs are held stable before the result is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  operands of requester N.
REQ-007 req0_sub / req1_sub  input  1  1 = a-b, 0 = a+b.
REQ-008 add_in1, add_in2  output  32  operands driven to the external 32-bit add/sub unit.
REQ-009 add_as  output  1  add/sub select driven to the unit.
REQ-010 add_out  input  32  sum from the unit; add_cout  input  1  carry-out from the unit.
REQ-011 rsp_valid  output  1  result available; rsp_ready  input  1  consumer takes result.
REQ-012 rsp_id  output  1  requester that owns the result; rsp_data  output  32; rsp_cout  output  1.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP only.
REQ-014 In IDLE, reqN_ready SHALL be high only for the granted requester; it SHALL be low in WAIT and RESP.
REQ-015 Grant in IDLE: single valid wins; if both valid, grant the requester other than last_grant (round-robin).
REQ-016 On handshake (valid&ready, cycle 0), the block SHALL latch a, b, sub and id, set last_grant = id, load counter with SETTLE_CYCLES, and enter WAIT.
REQ-017 add_in1/add_in2/add_as SHALL come from the latched registers only; they SHALL remain constant from cycle 1 until the next handshake.
REQ-018 The block SHALL decrement the counter once per cycle in WAIT; in the cycle it reads 1, it SHALL capture add_out/add_cout into rsp_data/rsp_cout and enter RESP.
REQ-019 rsp_valid SHALL be high in RESP only, first in cycle SETTLE_CYCLES+1 after handshake; rsp_id/rsp_data/rsp_cout SHALL remain stable while rsp_valid is high.
REQ-020 RESP SHALL exit to IDLE on rsp_valid&rsp_ready; no new request SHALL be accepted in that same cycle (one idle cycle between operations).
REQ-021 Request inputs changing during WAIT/RESP SHALL have no effect on the operation in flight.
REQ-022 No arithmetic is done in the block; rsp_data SHALL equal add_out bit-for-bit; 32-bit wrap-around is as delivered by the unit.

Reset
REQ-023 rst_n low at a rising edge SHALL force IDLE, counter 0, last_grant 1 (req0 wins first tie), operand/result registers 0, from any state including WAIT/RESP; the in-flight operation is discarded.
REQ-024 During and immediately after reset: req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_cout, add_in1, add_in2, add_as all 0.

Configuration
REQ-025 Macro ADDSUB_OVF_FLAG_EN defined: extra output rsp_ovf (1 bit), captured with rsp_data, = (a[31]==b'[31]) && (add_out[31]!=a[31]) where b' = b XOR {32{sub}}; reset value 0.
REQ-026 Macro undefined: port rsp_ovf and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE, WAIT, RESP), the data width constant 32 and the counter width constant 4.
REQ-028 Round-robin grant SHALL be a sub-module rr_pick2 (inputs two valids and last_grant; output grant-valid and grant-id, combinational).
REQ-029 The add/sub unit SHALL stay outside this block; the testbench instantiates it and connects the add_* ports.

Verification
REQ-030 Reset mid-WAIT: accept req0, assert rst_n=0 in cycle 1 -> cycle after: IDLE, all outputs 0, no rsp_valid ever for that op.
REQ-031 Single op, SETTLE_CYCLES=2: req0 a=0x7FFFFFFF b=1 sub=0 -> rsp_valid in cycle 3, rsp_id=0, rsp_data=0x80000000, rsp_cout=0, rsp_ovf=1 (with macro).
REQ-032 Subtract wrap: req1 a=0 b=1 sub=1 -> rsp_data=0xFFFFFFFF, rsp_cout=0, rsp_id=1, rsp_ovf=0.
REQ-033 Tie after reset: both valid every cycle -> grants alternate 0,1,0,1 over four ops; each op returns its own operands' result.
REQ-034 Backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and data stable all 5 cycles, no reqN_ready; release -> IDLE next cycle, next grant one cycle later.
REQ-035 Operand change: alter req0_a during WAIT -> add_in1 unchanged, result uses originally accepted operand.

Source files
------------

// File: rtl/addsub_arbiter_pkg.sv
// Shared types and widths for the two-requester add/sub arbiter.
// Holds the FSM state encoding plus the data and settle-counter widths.
package addsub_arbiter_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone valid wins, a tie goes to the
// requester that was not granted last time.
module rr_pick2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_id
);

   always_comb begin
      grant_valid = valid0 | valid1;
      grant_id    = (valid0 & valid1) ? ~last_grant : valid1;
   end

endmodule

// File: rtl/addsub_arbiter.sv
// Arbitrates two requesters onto one external 32-bit add/sub unit, holds its
// operands for SETTLE_CYCLES, then returns the result. Optional rsp_ovf: ADDSUB_OVF_FLAG_EN.
module addsub_arbiter
   import addsub_arbiter_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req0_sub,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic              req1_sub,
   output logic [DATA_W-1:0] add_in1,
   output logic [DATA_W-1:0] add_in2,
   output logic              add_as,
   input  logic [DATA_W-1:0] add_out,
   input  logic              add_cout,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_cout
`ifdef ADDSUB_OVF_FLAG_EN
   ,
   output logic              rsp_ovf
`endif
);

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              last_grant;
   logic              grant_valid;
   logic              grant_id;
   logic              accept;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              op_sub;
   logic              op_id;
   logic [DATA_W-1:0] res_data;
   logic              res_cout;

   rr_pick2 u_pick (
      .valid0      (req0_valid),
      .valid1      (req1_valid),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: default assignment first so no path through the case infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)                 state_nxt = WAIT;
         WAIT:    if (cnt == CNT_W'(1))       state_nxt = RESP;
         RESP:    if (rsp_ready)              state_nxt = IDLE;
         default:                             state_nxt = IDLE;
      endcase
   end

   // Handshake outputs are gated by rst_n so they read 0 while reset is held.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp_valid  = 1'b0;
      if (rst_n) begin
         case (state)
            IDLE: begin
               req0_ready = grant_valid & ~grant_id;
               req1_ready = grant_valid &  grant_id;
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         last_grant <= 1'b1;
         op_a       <= '0;
         op_b       <= '0;
         op_sub     <= 1'b0;
         op_id      <= 1'b0;
         res_data   <= '0;
         res_cout   <= 1'b0;
      end else if (accept) begin
         op_id      <= grant_id;
         last_grant <= grant_id;
         op_a       <= grant_id ? req1_a   : req0_a;
         op_b       <= grant_id ? req1_b   : req0_b;
         op_sub     <= grant_id ? req1_sub : req0_sub;
         cnt        <= SETTLE_LOAD;
      end else if (state == WAIT) begin
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            res_data <= add_out;
            res_cout <= add_cout;
         end
      end
   end

`ifdef ADDSUB_OVF_FLAG_EN
   logic [DATA_W-1:0] b_eff;
   logic              res_ovf;

   // Signed overflow seen through the operand the unit actually adds.
   assign b_eff = op_b ^ {DATA_W{op_sub}};

   always_ff @(posedge clk) begin
      if (!rst_n)
         res_ovf <= 1'b0;
      else if (!accept && state == WAIT && cnt == CNT_W'(1))
         res_ovf <= (op_a[DATA_W-1] == b_eff[DATA_W-1]) &&
                    (add_out[DATA_W-1] != op_a[DATA_W-1]);
   end

   assign rsp_ovf = res_ovf;
`endif

   assign add_in1  = op_a;
   assign add_in2  = op_b;
   assign add_as   = op_sub;
   assign rsp_id   = op_id;
   assign rsp_data = res_data;
   assign rsp_cout = res_cout;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: transaction-level model checked every cycle on the
// falling edge, plus directed scenarios with hand-computed literal results.
module tb_addsub_arbiter;
   import addsub_arbiter_pkg::*;

   localparam int SETTLE = 2;

   typedef struct {
      bit          id;
      logic [31:0] a;
      logic [31:0] b;
      bit          sub;
      logic [31:0] res;
      bit          cout;
      bit          ovf;
   } op_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        req0_sub = 1'b0, req1_sub = 1'b0;
   logic [31:0] add_in1, add_in2, add_out;
   logic        add_as, add_cout;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_cout;
   logic [31:0] rsp_data;
`ifdef ADDSUB_OVF_FLAG_EN
   logic        rsp_ovf;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External add/sub unit.
   assign {add_cout, add_out} = {1'b0, add_in1} + {1'b0, add_in2 ^ {32{add_as}}} + {32'd0, add_as};

   addsub_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_sub   (req0_sub),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_sub   (req1_sub),
      .add_in1    (add_in1),
      .add_in2    (add_in2),
      .add_as     (add_as),
      .add_out    (add_out),
      .add_cout   (add_cout),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_cout   (rsp_cout)
`ifdef ADDSUB_OVF_FLAG_EN
      ,
      .rsp_ovf    (rsp_ovf)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Result of an operation derived from plain integer arithmetic.
   function automatic op_t make_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                                   input bit sub);
      op_t    o;
      longint sa, sb, sr;
      o.id  = id;
      o.a   = a;
      o.b   = b;
      o.sub = sub;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      if (sub) begin
         o.res  = a - b;
         o.cout = (a >= b);
         sr     = sa - sb;
      end else begin
         o.res  = a + b;
         o.cout = ((64'(a) + 64'(b)) >> 32) != 64'd0;
         sr     = sa + sb;
      end
      o.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return o;
   endfunction

   // Model state: busy with an op of a given age, or idle.
   bit   m_known = 1'b0;
   bit   m_busy  = 1'b0;
   bit   m_last  = 1'b1;
   bit   m_fresh = 1'b0;
   int   m_age   = 0;
   int   m_hs_cyc = 0;
   op_t  m_cur;
   op_t  m_shown;
   op_t  m_zero;
   bit   grant_log[$];
   bit   e_r0, e_r1, e_rv, e_gv, e_g;

   initial begin
      m_zero = make_op(1'b0, 32'd0, 32'd0, 1'b0);
      m_shown = m_zero;
      m_cur   = m_zero;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         check("ready0_in_reset", 32'(req0_ready), 32'd0);
         check("ready1_in_reset", 32'(req1_ready), 32'd0);
         check("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
         m_busy  = 1'b0;
         m_last  = 1'b1;
         m_shown = m_zero;
         m_fresh = 1'b1;
         m_known = 1'b1;
      end else if (m_known) begin
         e_r0 = 1'b0; e_r1 = 1'b0; e_rv = 1'b0; e_gv = 1'b0; e_g = 1'b0;
         if (!m_busy) begin
            e_gv = req0_valid | req1_valid;
            e_g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e_r0 = e_gv && !e_g;
            e_r1 = e_gv && e_g;
         end else begin
            m_age++;
            e_rv = (m_age >= SETTLE + 1);
         end
         check("req0_ready", 32'(req0_ready), 32'(e_r0));
         check("req1_ready", 32'(req1_ready), 32'(e_r1));
         check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
         check("add_in1", add_in1, m_shown.a);
         check("add_in2", add_in2, m_shown.b);
         check("add_as", 32'(add_as), 32'(m_shown.sub));
         if (e_rv || m_fresh) begin
            check("rsp_id", 32'(rsp_id), 32'(m_fresh ? 1'b0 : m_cur.id));
            check("rsp_data", rsp_data, m_fresh ? 32'd0 : m_cur.res);
            check("rsp_cout", 32'(rsp_cout), 32'(m_fresh ? 1'b0 : m_cur.cout));
`ifdef ADDSUB_OVF_FLAG_EN
            check("rsp_ovf", 32'(rsp_ovf), 32'(m_fresh ? 1'b0 : m_cur.ovf));
`endif
         end
         m_fresh = 1'b0;
         if (!m_busy && e_gv) begin
            m_cur = e_g ? make_op(1'b1, req1_a, req1_b, req1_sub)
                        : make_op(1'b0, req0_a, req0_b, req0_sub);
            m_shown  = m_cur;
            m_busy   = 1'b1;
            m_age    = 0;
            m_last   = e_g;
            m_hs_cyc = cyc;
            grant_log.push_back(e_g);
         end else if (e_rv && rsp_ready) begin
            m_busy = 1'b0;
         end
      end
   end

   // Present an op on one requester until it is accepted, then withdraw it.
   task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b, input bit sub);
      bit done = 1'b0;
      if (id) begin req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1; end
      else    begin req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1; end
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge clk);
         done = id ? req1_ready : req0_ready;
      end
      if (!done) check("issue_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   // Stop at the falling edge of the first cycle with rsp_valid high.
   task automatic wait_rsp(output int lat);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = rsp_valid;
      end
      if (!seen) check("rsp_timeout", 32'd0, 32'd1);
      lat = cyc - m_hs_cyc;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
   endtask

   int lat;
   int seen_valid;

   initial begin
      // Reset with a request pending: ready must stay low throughout.
      req0_valid = 1'b1;
      idle_cycles(3);
      req0_valid = 1'b0;
      rst_n      = 1'b1;
      idle_cycles(2);

      // 0x7FFFFFFF + 1 on req0.
      rsp_ready = 1'b1;
      issue(1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0);
      wait_rsp(lat);
      check("lat_single", 32'(lat), 32'd3);
      check("single_id", 32'(rsp_id), 32'd0);
      check("single_data", rsp_data, 32'h8000_0000);
      check("single_cout", 32'(rsp_cout), 32'd0);
`ifdef ADDSUB_OVF_FLAG_EN
      check("single_ovf", 32'(rsp_ovf), 32'd1);
`endif
      idle_cycles(2);

      // 0 - 1 on req1 wraps.
      issue(1'b1, 32'd0, 32'd1, 1'b1);
      wait_rsp(lat);
      check("wrap_id", 32'(rsp_id), 32'd1);
      check("wrap_data", rsp_data, 32'hFFFF_FFFF);
      check("wrap_cout", 32'(rsp_cout), 32'd0);
`ifdef ADDSUB_OVF_FLAG_EN
      check("wrap_ovf", 32'(rsp_ovf), 32'd0);
`endif
      idle_cycles(2);

      // Operand changes during WAIT are ignored.
      issue(1'b0, 32'd1000, 32'd1, 1'b0);
      req0_a = 32'd5;
      @(negedge clk);
      check("hold_in1_c1", add_in1, 32'd1000);
      @(negedge clk);
      check("hold_in1_c2", add_in1, 32'd1000);
      wait_rsp(lat);
      check("hold_data", rsp_data, 32'd1001);
      idle_cycles(2);

      // Backpressure: response held for 5 cycles, req1 waiting.
      rsp_ready = 1'b0;
      issue(1'b0, 32'd100, 32'd23, 1'b0);
      req1_a = 32'd7; req1_b = 32'd7; req1_sub = 1'b1; req1_valid = 1'b1;
      wait_rsp(lat);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_data", rsp_data, 32'd123);
         check("bp_no_ready1", 32'(req1_ready), 32'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_exit_no_ready1", 32'(req1_ready), 32'd0);
      @(negedge clk);
      check("bp_next_grant", 32'(req1_ready), 32'd1);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      wait_rsp(lat);
      check("bp_next_id", 32'(rsp_id), 32'd1);
      check("bp_next_data", rsp_data, 32'd0);
      idle_cycles(2);

      // Reset in the first WAIT cycle discards the op.
      issue(1'b0, 32'd9, 32'd9, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_valid", 32'(rsp_valid), 32'd0);
      check("rst_mid_in1", add_in1, 32'd0);
      check("rst_mid_data", rsp_data, 32'd0);
      seen_valid = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid) seen_valid++;
      end
      check("rst_mid_no_rsp", 32'(seen_valid), 32'd0);

      // Tie after reset: grants alternate starting with req0.
      grant_log.delete();
      req0_a = 32'd5;  req0_b = 32'd3; req0_sub = 1'b0;
      req1_a = 32'd10; req1_b = 32'd4; req1_sub = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 60 && grant_log.size() < 4; i++) begin
         @(posedge clk); #1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("tie_count", 32'(grant_log.size()), 32'd4);
      if (grant_log.size() >= 4) begin
         check("tie_g0", 32'(grant_log[0]), 32'd0);
         check("tie_g1", 32'(grant_log[1]), 32'd1);
         check("tie_g2", 32'(grant_log[2]), 32'd0);
         check("tie_g3", 32'(grant_log[3]), 32'd1);
      end
      wait_rsp(lat);
      check("tie_last_data", rsp_data, 32'd6);
      idle_cycles(3);
      check("drained", 32'(m_busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
